// File: rtl/ej32_pkg.sv
// ej32_pkg: shared types and defaults for the EJ32 arithmetic unit.
// Revision 1.0
`default_nettype none

package ej32_pkg;
    localparam int DSZ_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_st_t;
endpackage

`default_nettype wire

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract step on unsigned magnitudes.
// Revision 1.0
`default_nettype none

module div_step
    import ej32_pkg::*;
#(
    parameter int DSZ = DSZ_DEFAULT
) (
    input  logic [DSZ:0]   pr_i,
    input  logic [DSZ-1:0] d_i,
    input  logic           bit_i,
    output logic [DSZ:0]   pr_o,
    output logic           qbit_o
);
    logic [DSZ+1:0] sh;
    logic [DSZ+1:0] diff;

    // One guard bit above the shifted remainder turns the borrow into the quotient bit.
    always_comb begin
        sh     = {pr_i, bit_i};
        diff   = sh - {2'b00, d_i};
        qbit_o = ~diff[DSZ+1];
        pr_o   = qbit_o ? diff[DSZ:0] : sh[DSZ:0];
    end
endmodule

`default_nettype wire

// File: rtl/ej32_div_ctl.sv
// ej32_div_ctl: multi-cycle signed divide (idiv/irem) with Java truncation semantics.
// Revision 1.0
`default_nettype none

module ej32_div_ctl
    import ej32_pkg::*;
#(
    parameter int DSZ = DSZ_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           op_rem,
    input  logic           flush,
    input  logic [DSZ-1:0] x,
    input  logic [DSZ-1:0] y,
    output logic           busy,
    output logic           done,
    output logic           dbz,
    output logic [DSZ-1:0] q,
    output logic [DSZ-1:0] r,
    output logic [DSZ-1:0] res
);
    localparam int CW = (DSZ > 1) ? $clog2(DSZ) : 1;

    div_st_t        st_q;
    logic [CW-1:0]  cnt_q;
    logic [DSZ:0]   pr_q;
    logic [DSZ-1:0] dvd_q;
    logic [DSZ-1:0] dvs_q;
    logic           xneg_q;
    logic           qneg_q;
    logic           sel_q;
    logic           busy_q;
    logic           done_q;
    logic           dbz_q;
    logic [DSZ-1:0] q_q;
    logic [DSZ-1:0] r_q;
    logic [DSZ-1:0] res_q;

    logic [DSZ:0]   pr_d;
    logic           qbit_d;
    logic [DSZ-1:0] x_abs_d;
    logic [DSZ-1:0] y_abs_d;
    logic [DSZ-1:0] q_fix_d;
    logic [DSZ-1:0] r_fix_d;

    // The dividend register doubles as the quotient shift register.
    div_step #(.DSZ(DSZ)) u_step (
        .pr_i   (pr_q),
        .d_i    (dvs_q),
        .bit_i  (dvd_q[DSZ-1]),
        .pr_o   (pr_d),
        .qbit_o (qbit_d)
    );

    always_comb begin
        x_abs_d = x[DSZ-1] ? -x : x;
        y_abs_d = y[DSZ-1] ? -y : y;
        q_fix_d = qneg_q ? -dvd_q : dvd_q;
        r_fix_d = xneg_q ? -pr_q[DSZ-1:0] : pr_q[DSZ-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            pr_q   <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            xneg_q <= 1'b0;
            qneg_q <= 1'b0;
            sel_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            res_q  <= '0;
        end else if (flush) begin
            st_q   <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        sel_q  <= op_rem;
                        if (y == '0) begin
                            q_q    <= '1;
                            r_q    <= x;
                            res_q  <= op_rem ? x : '1;
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                            st_q   <= DONE;
                        end else begin
                            pr_q   <= '0;
                            dvd_q  <= x_abs_d;
                            dvs_q  <= y_abs_d;
                            xneg_q <= x[DSZ-1];
                            qneg_q <= x[DSZ-1] ^ y[DSZ-1];
                            cnt_q  <= '0;
                            st_q   <= ITER;
                        end
                    end
                end
                ITER: begin
                    pr_q  <= pr_d;
                    dvd_q <= {dvd_q[DSZ-2:0], qbit_d};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DSZ - 1)) begin
                        st_q <= FIX;
                    end
                end
                FIX: begin
                    q_q    <= q_fix_d;
                    r_q    <= r_fix_d;
                    res_q  <= sel_q ? r_fix_d : q_fix_d;
                    dbz_q  <= 1'b0;
                    done_q <= 1'b1;
                    st_q   <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    st_q   <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    st_q   <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign q    = q_q;
    assign r    = r_q;
    assign res  = res_q;
endmodule

`default_nettype wire

// File: tb/tb_ej32_div_ctl.sv
// tb_ej32_div_ctl: randomized and directed checks of ej32_div_ctl against a latency/arithmetic model.
// Revision 1.0
`default_nettype none

module tb_ej32_div_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op_rem = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] s_x = '0;
    logic [31:0] s_y = '0;
    logic        busy, done, dbz;
    logic [31:0] q, r, res;

    int n_chk = 0;
    int n_fail = 0;

    ej32_div_ctl #(.DSZ(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_rem(op_rem), .flush(flush),
        .x(s_x), .y(s_y), .busy(busy), .done(done), .dbz(dbz),
        .q(q), .r(r), .res(res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Java idiv/irem via wide signed arithmetic; y==0 gives the all-ones/x convention.
    function automatic void java_div(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] qq, output logic [31:0] rr);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            qq = 32'hFFFF_FFFF;
            rr = a;
        end else begin
            qq = 32'(sa / sb);
            rr = 32'(sa % sb);
        end
    endfunction

    // Model: an accepted op keeps busy for a fixed number of edges, done on the last of them.
    int          m_left = 0;
    logic        e_busy = 0, e_done = 0, e_dbz = 0;
    logic [31:0] e_q = 0, e_r = 0, e_res = 0;
    logic        p_dbz;
    logic [31:0] p_q, p_r, p_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; e_busy = 0; e_done = 0; e_dbz = 0;
            e_q = 0; e_r = 0; e_res = 0;
        end else begin
            e_done = 0;
            if (flush) begin
                m_left = 0;
            end else if (m_left == 0) begin
                if (start) begin
                    java_div(s_x, s_y, p_q, p_r);
                    p_res  = op_rem ? p_r : p_q;
                    p_dbz  = (s_y == 32'd0);
                    m_left = p_dbz ? 1 : 34;
                end
            end else begin
                m_left--;
            end
            if (!flush && m_left == 1 && !e_done) begin
                e_done = 1;
                e_q = p_q; e_r = p_r; e_res = p_res; e_dbz = p_dbz;
            end
            e_busy = (m_left != 0);
        end
    end

    always begin
        @(negedge clk);
        #1;
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("done", {31'b0, done}, {31'b0, e_done});
        chk("dbz",  {31'b0, dbz},  {31'b0, e_dbz});
        chk("q",    q,   e_q);
        chk("r",    r,   e_r);
        chk("res",  res, e_res);
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic op);
        @(negedge clk);
        s_x = a; s_y = b; op_rem = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_chk(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input int elat, input logic [31:0] eq,
                           input logic [31:0] er, input logic [31:0] eres, input logic edbz);
        int lat;
        launch(a, b, op);
        wait_done(1, lat);
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_q"}, q, eq);
        chk({nm, "_r"}, r, er);
        chk({nm, "_res"}, res, eres);
        chk({nm, "_dbz"}, {31'b0, dbz}, {31'b0, edbz});
        @(negedge clk);
        chk({nm, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat;
        int k;
        bit saw_done;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_q", q, 32'd0);
        chk("rst_res", res, 32'd0);
        rst = 1'b0;

        run_chk("div100_7", 32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 32'd14, 1'b0);
        run_chk("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_chk("dbz5", 32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_chk("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 34, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0);

        // Re-pulsed start while busy must be ignored.
        launch(32'd100, 32'd7, 1'b0);
        repeat (8) @(negedge clk);
        s_x = 32'd50; s_y = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, lat);
        chk("repulse_lat", 32'(lat), 32'd34);
        chk("repulse_q", q, 32'd14);
        chk("repulse_r", r, 32'd2);
        @(negedge clk);

        // Reset mid-iteration.
        launch(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #2;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_q", q, 32'd0);
        chk("midrst_r", r, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("midrst_nodone", {31'b0, saw_done}, 32'd0);
        run_chk("div9_3a", 32'd9, 32'd3, 1'b0, 34, 32'd3, 32'd0, 32'd3, 1'b0);

        // Flush mid-iteration keeps the previous result.
        launch(32'd100, 32'd7, 1'b1);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        saw_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("flush_nodone", {31'b0, saw_done}, 32'd0);
        chk("flush_hold_q", q, 32'd3);
        run_chk("rem9_3", 32'd9, 32'd3, 1'b1, 34, 32'd3, 32'd0, 32'd0, 1'b0);

        // Flush beats start in the same cycle.
        @(negedge clk);
        s_x = 32'd8; s_y = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_prio", {31'b0, busy}, 32'd0);

        // Random operations with stray starts and occasional flushes.
        for (int n = 0; n < 40; n++) begin
            launch(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
            k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 36)) : 0;
            for (int i = 1; i <= 37; i++) begin
                @(negedge clk);
                flush = (i == k);
                start = ($urandom_range(0, 15) == 0);
                if (start) begin
                    s_x = rnd_val(); s_y = rnd_val(); op_rem = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
        end
        repeat (40) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
